mp64_extmem_sram_phy: RTL and testbench
=======================================

// Module: mp64_extmem_sram_phy
// PURPOSE
//   PHY-side burst sequencer directly downstream of mp64_extmem. It consumes the phy_* burst
//   interface (single-beat CPU, 8-beat tile) and serves each beat from an external synchronous
//   64-bit SRAM, which has a fixed read latency and programmable write wait states.
//   It returns one phy_ack pulse per beat.
// PARAMETERS
//   SRAM_AW   20  SRAM word-address width (64-bit words)
//   RD_LAT    2   cycles from address issue to valid sram_dq_i
//   WR_WAIT   1   extra cycles sram_we_n is held low per write beat
// PORTS
//   clk            in   1        system clock
//   rst_n          in   1        async active-low reset
//   phy_req        in   1        transaction request, held by upstream for the whole burst
//   phy_addr       in   32       burst base byte address; [2:0] ignored
//   phy_wdata      in   64       current write beat; upstream advances it after each phy_ack
//   phy_wen        in   1        1=write, 0=read
//   phy_burst_len  in   4        beats: legal 1..8
//   phy_rdata      out  64       registered read beat, valid while phy_ack=1, then held
//   phy_ack        out  1        one-cycle pulse per completed beat
//   sram_ce_n      out  1        chip enable, low while a beat is issued or written
//   sram_we_n      out  1        write strobe
//   sram_addr      out  SRAM_AW  word address
//   sram_dq_o      out  64       write data
//   sram_dq_oe     out  1        1 = drive sram_dq_o onto the bus
//   sram_dq_i      in   64       read data
//   stat_rd_beats  out  32       read-beat counter (see CONFIGURATION)
//   stat_wr_beats  out  32       write-beat counter
// BEHAVIOUR
//   Reset values (async): phy_ack=0, phy_rdata=0, sram_ce_n=1, sram_we_n=1, sram_dq_oe=0,
//     sram_addr=0, sram_dq_o=0, stats=0. State is IDLE.
//   FSM states: IDLE, ISSUE, RWAIT, WRITE, ACK, DONE.
//   IDLE: when phy_req=1 at a posedge, latch the following, then go to ISSUE:
//     base word = phy_addr[SRAM_AW+2:3]; phy_addr bits above that alias.
//     wen.
//     beats: burst_len 0 is treated as 1; 9..15 are clamped to 8.
//     beat counter = 0.
//   ISSUE (1 cycle):
//     sram_addr = (base + beat) mod 2^SRAM_AW, i.e. the address wraps at the top of the SRAM.
//     sram_ce_n = 0.
//     Read: go to RWAIT.
//     Write: sram_we_n=0, sram_dq_oe=1, sram_dq_o=phy_wdata sampled this cycle; go to WRITE.
//   RWAIT: RD_LAT cycles. At the end of the last one, register sram_dq_i into phy_rdata; go to ACK.
//   WRITE: WR_WAIT cycles holding we_n, ce_n, dq_oe and dq_o stable. WR_WAIT=0 skips this state.
//     At exit deassert we_n, ce_n and dq_oe; go to ACK.
//   ACK (1 cycle): phy_ack=1 and beat increments.
//     If beat+1 < beats: go to ISSUE.
//     Otherwise: go to DONE.
//   DONE (1 cycle): phy_req is ignored, giving upstream turnaround; then go to IDLE.
//     Upstream must deassert or re-present phy_req by the cycle after DONE.
//   Latency from the posedge that samples phy_req to the first phy_ack:
//     read: RD_LAT+2 cycles.
//     write: WR_WAIT+2 cycles.
//   Beat period: read RD_LAT+2 cycles, write WR_WAIT+2 cycles.
//   phy_req dropping mid-burst is not legal. The FSM completes the latched burst regardless.
//   phy_addr, phy_wen and phy_burst_len are sampled only in IDLE.
//   Reset mid-burst: all outputs return to reset values at once and no further acks are issued.
//   Reads never assert sram_we_n. sram_dq_oe is never 1 in the same cycle as a read issue.
// CONFIGURATION
//   MP64_EXTMEM_PHY_STATS_EN defined:
//     stat_rd_beats / stat_wr_beats increment on each ACK of the corresponding type.
//     They wrap at 2^32 and clear on reset.
//   MP64_EXTMEM_PHY_STATS_EN undefined: both ports are tied to 0 and no counter flops exist.
// STRUCTURE
//   mp64_extmem_pkg holds:
//     MP64_BEAT_W=64
//     MP64_BURST_CPU=1, MP64_BURST_TILE=8
//     the FSM state encoding localparams (3 bits)
//   Optional sub-module mp64_phy_stats: the two counters, instantiated only under the macro.
//     Wait counters stay inline.
// TESTING (bench: RD_LAT=2, WR_WAIT=1, SRAM_AW=10, behavioural SRAM model, negedge-driven)
//   1. Reset, then hold rst_n low 3 cycles
//      -> phy_ack=0, sram_ce_n=1, sram_we_n=1, sram_dq_oe=0, stats=0.
//   2. Read: mem[0x020]=0xDEADBEEF12345678; phy_addr=0x8000_0100, len=1
//      -> sram_addr=0x020; one phy_ack exactly 4 cycles after req sampled;
//         phy_rdata=0xDEADBEEF12345678.
//   3. 8-beat write at 0xB000_0000; upstream advances wdata 0xAA000000+i after each ack
//      -> mem[0..7]=0xAA000000..0xAA000007; 8 acks spaced 3 cycles apart; we_n low 2 cycles per beat.
//   4. Wrap: 8-beat read at phy_addr=0x1FF8
//      -> sram_addr sequence 0x3FF,0x000..0x006; rdata in that order.
//   5. Length edges: len=0 -> 1 ack; len=12 -> 8 acks; then DONE, then IDLE.
//      With the macro: stat_rd_beats=9.
//   6. Reset asserted after the 3rd ack of an 8-beat read
//      -> outputs reset immediately, no 4th ack; a later len=1 read completes normally.

Source files
------------

// File: rtl/mp64_extmem_pkg.sv
// Shared constants for the mp64 external-memory path: beat width, burst sizes,
// PHY sequencer state encoding and the burst-length clamp.
package mp64_extmem_pkg;

  localparam int MP64_BEAT_W     = 64;
  localparam int MP64_BURST_CPU  = 1;
  localparam int MP64_BURST_TILE = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_RWAIT = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_ACK   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Zero-length requests become a single CPU beat; oversize ones a full tile.
  function automatic logic [3:0] mp64_clamp_beats(input logic [3:0] len);
    if (len == 4'd0)
      return 4'(MP64_BURST_CPU);
    else if (len > 4'(MP64_BURST_TILE))
      return 4'(MP64_BURST_TILE);
    else
      return len;
  endfunction

endpackage

// File: rtl/mp64_phy_stats.sv
// Read/write beat counters for the SRAM PHY; free-running, wrap at 2^32.
module mp64_phy_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rd_inc,
  input  logic        i_wr_inc,
  output logic [31:0] o_rd_beats,
  output logic [31:0] o_wr_beats
);

  logic [31:0] r_rd_beats;
  logic [31:0] r_wr_beats;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_beats <= 32'd0;
      r_wr_beats <= 32'd0;
    end else begin
      if (i_rd_inc) r_rd_beats <= r_rd_beats + 32'd1;
      if (i_wr_inc) r_wr_beats <= r_wr_beats + 32'd1;
    end
  end

  assign o_rd_beats = r_rd_beats;
  assign o_wr_beats = r_wr_beats;

endmodule

// File: rtl/mp64_extmem_sram_phy.sv
// Burst sequencer serving phy_* beats from a synchronous 64-bit SRAM.
// Beat counters are built only when MP64_EXTMEM_PHY_STATS_EN is defined.
module mp64_extmem_sram_phy
  import mp64_extmem_pkg::*;
#(
  parameter int SRAM_AW = 20,
  parameter int RD_LAT  = 2,
  parameter int WR_WAIT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   phy_req,
  input  logic [31:0]            phy_addr,
  input  logic [MP64_BEAT_W-1:0] phy_wdata,
  input  logic                   phy_wen,
  input  logic [3:0]             phy_burst_len,
  output logic [MP64_BEAT_W-1:0] phy_rdata,
  output logic                   phy_ack,
  output logic                   sram_ce_n,
  output logic                   sram_we_n,
  output logic [SRAM_AW-1:0]     sram_addr,
  output logic [MP64_BEAT_W-1:0] sram_dq_o,
  output logic                   sram_dq_oe,
  input  logic [MP64_BEAT_W-1:0] sram_dq_i,
  output logic [31:0]            stat_rd_beats,
  output logic [31:0]            stat_wr_beats
);

  localparam logic [7:0] RD_LAST = 8'(RD_LAT - 1);
  localparam logic [7:0] WR_LAST = 8'(WR_WAIT - 1);

  logic [2:0]             r_state;
  logic [SRAM_AW-1:0]     r_addr;
  logic                   r_wen;
  logic [3:0]             r_beats;
  logic [3:0]             r_beat;
  logic [7:0]             r_wait;
  logic [MP64_BEAT_W-1:0] r_rdata;
  logic [MP64_BEAT_W-1:0] r_dq;
  logic                   w_active;
  logic                   w_unused_addr;

  assign w_unused_addr = ^{phy_addr[31:SRAM_AW+3], phy_addr[2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_beats <= 4'd0;
      r_beat  <= 4'd0;
      r_wait  <= 8'd0;
      r_rdata <= '0;
      r_dq    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (phy_req) begin
            r_addr  <= phy_addr[SRAM_AW+2:3];
            r_wen   <= phy_wen;
            r_beats <= mp64_clamp_beats(phy_burst_len);
            r_beat  <= 4'd0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_wait <= 8'd0;
          if (r_wen) begin
            r_dq    <= phy_wdata;
            r_state <= (WR_WAIT == 0) ? ST_ACK : ST_WRITE;
          end else if (RD_LAT == 0) begin
            r_rdata <= sram_dq_i;
            r_state <= ST_ACK;
          end else begin
            r_state <= ST_RWAIT;
          end
        end
        ST_RWAIT: begin
          if (r_wait == RD_LAST) begin
            r_rdata <= sram_dq_i;
            r_state <= ST_ACK;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        ST_WRITE: begin
          if (r_wait == WR_LAST) r_state <= ST_ACK;
          else                   r_wait  <= r_wait + 8'd1;
        end
        ST_ACK: begin
          r_beat <= r_beat + 4'd1;
          // Word address wraps naturally at the top of the SRAM.
          if (r_beat + 4'd1 < r_beats) begin
            r_addr  <= r_addr + SRAM_AW'(1);
            r_state <= ST_ISSUE;
          end else begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // SRAM strobes decode straight from state so reset releases the bus at once.
  assign w_active   = (r_state == ST_ISSUE) || (r_state == ST_WRITE);
  assign sram_ce_n  = ~w_active;
  assign sram_we_n  = ~(w_active & r_wen);
  assign sram_dq_oe = w_active & r_wen;
  assign sram_dq_o  = ((r_state == ST_ISSUE) && r_wen) ? phy_wdata : r_dq;
  assign sram_addr  = r_addr;
  assign phy_ack    = (r_state == ST_ACK);
  assign phy_rdata  = r_rdata;

`ifdef MP64_EXTMEM_PHY_STATS_EN
  mp64_phy_stats u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_inc   (phy_ack & ~r_wen),
    .i_wr_inc   (phy_ack & r_wen),
    .o_rd_beats (stat_rd_beats),
    .o_wr_beats (stat_wr_beats)
  );
`else
  assign stat_rd_beats = 32'd0;
  assign stat_wr_beats = 32'd0;
`endif

endmodule

// File: tb/tb_mp64_extmem_sram_phy.sv
// Directed bench for mp64_extmem_sram_phy with a behavioural 2-cycle-latency SRAM.
module tb_mp64_extmem_sram_phy;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        phy_req;
  logic [31:0] phy_addr;
  logic [63:0] phy_wdata;
  logic        phy_wen;
  logic [3:0]  phy_burst_len;
  logic [63:0] phy_rdata;
  logic        phy_ack;
  logic        sram_ce_n;
  logic        sram_we_n;
  logic [9:0]  sram_addr;
  logic [63:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [63:0] sram_dq_i;
  logic [31:0] stat_rd_beats;
  logic [31:0] stat_wr_beats;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem [0:1023];
  logic [63:0] rd1 = 64'h0;
  logic [63:0] rd2 = 64'h0;
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = 10'h0;
  logic [63:0] pre_data = 64'h0;

  int          n_ack, n_iss, we_low, oe_on_read, extra_ack, ce_after;
  bit          timed_out;
  int          ack_cyc [16];
  logic [63:0] ack_data [16];
  logic [9:0]  iss_addr [16];

  mp64_extmem_sram_phy #(.SRAM_AW(10), .RD_LAT(2), .WR_WAIT(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .phy_req       (phy_req),
    .phy_addr      (phy_addr),
    .phy_wdata     (phy_wdata),
    .phy_wen       (phy_wen),
    .phy_burst_len (phy_burst_len),
    .phy_rdata     (phy_rdata),
    .phy_ack       (phy_ack),
    .sram_ce_n     (sram_ce_n),
    .sram_we_n     (sram_we_n),
    .sram_addr     (sram_addr),
    .sram_dq_o     (sram_dq_o),
    .sram_dq_oe    (sram_dq_oe),
    .sram_dq_i     (sram_dq_i),
    .stat_rd_beats (stat_rd_beats),
    .stat_wr_beats (stat_wr_beats)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we)
      mem[pre_addr] <= pre_data;
    else if (!sram_ce_n && !sram_we_n && sram_dq_oe)
      mem[sram_addr] <= sram_dq_o;
    rd1 <= (!sram_ce_n && sram_we_n) ? mem[sram_addr] : 64'h0;
    rd2 <= rd1;
  end
  assign sram_dq_i = rd2;

  task automatic preload(input logic [9:0] a, input logic [63:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n   = 1'b0;
    phy_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_burst(input logic [31:0] addr, input logic wen, input logic [3:0] len,
                           input int exp_acks, input logic [63:0] wbase);
    int cyc;
    n_ack = 0; n_iss = 0; we_low = 0; oe_on_read = 0; extra_ack = 0; ce_after = 0;
    timed_out = 0;
    @(negedge clk);
    phy_addr = addr; phy_wen = wen; phy_burst_len = len; phy_wdata = wbase; phy_req = 1'b1;
    cyc = 0;
    while (n_ack < exp_acks && !timed_out) begin
      @(negedge clk);
      cyc++;
      if (!sram_ce_n && sram_we_n) begin
        if (n_iss < 16) iss_addr[n_iss] = sram_addr;
        n_iss++;
        if (sram_dq_oe) oe_on_read++;
      end
      if (!sram_we_n) we_low++;
      if (phy_ack) begin
        if (n_ack < 16) begin
          ack_cyc[n_ack]  = cyc;
          ack_data[n_ack] = phy_rdata;
        end
        n_ack++;
        phy_wdata = wbase + 64'(n_ack);
        if (n_ack == exp_acks) phy_req = 1'b0;
      end
      if (cyc > 200) timed_out = 1;
    end
    phy_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (phy_ack) extra_ack++;
      if (!sram_ce_n) ce_after++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; phy_req = 1'b0; phy_addr = 32'h0; phy_wdata = 64'h0;
    phy_wen = 1'b0; phy_burst_len = 4'd1;
    repeat (3) @(negedge clk);
    checks++; if (phy_ack !== 1'b0)     begin errors++; $display("FAIL reset_ack got %0b want 0", phy_ack); end
    checks++; if (sram_ce_n !== 1'b1)   begin errors++; $display("FAIL reset_ce_n got %0b want 1", sram_ce_n); end
    checks++; if (sram_we_n !== 1'b1)   begin errors++; $display("FAIL reset_we_n got %0b want 1", sram_we_n); end
    checks++; if (sram_dq_oe !== 1'b0)  begin errors++; $display("FAIL reset_oe got %0b want 0", sram_dq_oe); end
    checks++; if (phy_rdata !== 64'h0)  begin errors++; $display("FAIL reset_rdata got %h want 0", phy_rdata); end
    checks++; if (sram_addr !== 10'h0)  begin errors++; $display("FAIL reset_addr got %h want 0", sram_addr); end
    checks++; if (sram_dq_o !== 64'h0)  begin errors++; $display("FAIL reset_dq_o got %h want 0", sram_dq_o); end
    checks++; if (stat_rd_beats !== 32'd0 || stat_wr_beats !== 32'd0)
      begin errors++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat_rd_beats, stat_wr_beats); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    preload(10'h020, 64'hDEADBEEF12345678);
    run_burst(32'h8000_0100, 1'b0, 4'd1, 1, 64'h0);
    checks++; if (timed_out)              begin errors++; $display("FAIL rd1_timeout got %0d acks want 1", n_ack); end
    checks++; if (n_iss !== 1 || iss_addr[0] !== 10'h020)
      begin errors++; $display("FAIL rd1_addr got %h (%0d issues) want 020", iss_addr[0], n_iss); end
    checks++; if (ack_cyc[0] !== 4)       begin errors++; $display("FAIL rd1_latency got %0d want 4", ack_cyc[0]); end
    checks++; if (ack_data[0] !== 64'hDEADBEEF12345678)
      begin errors++; $display("FAIL rd1_data got %h want deadbeef12345678", ack_data[0]); end
    checks++; if (extra_ack !== 0)        begin errors++; $display("FAIL rd1_extra_ack got %0d want 0", extra_ack); end
    checks++; if (phy_rdata !== 64'hDEADBEEF12345678)
      begin errors++; $display("FAIL rd1_hold got %h want deadbeef12345678", phy_rdata); end
  endtask

  task automatic test_tile_write();
    run_burst(32'hB000_0000, 1'b1, 4'd8, 8, 64'hAA000000);
    checks++; if (timed_out)       begin errors++; $display("FAIL wr8_timeout got %0d acks want 8", n_ack); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (mem[i] !== 64'hAA000000 + 64'(i))
        begin errors++; $display("FAIL wr8_mem[%0d] got %h want %h", i, mem[i], 64'hAA000000 + 64'(i)); end
      checks++; if (ack_cyc[i] !== 3 * (i + 1))
        begin errors++; $display("FAIL wr8_ack_cyc[%0d] got %0d want %0d", i, ack_cyc[i], 3 * (i + 1)); end
    end
    checks++; if (we_low !== 16)   begin errors++; $display("FAIL wr8_we_low got %0d want 16", we_low); end
    checks++; if (n_iss !== 0)     begin errors++; $display("FAIL wr8_read_issue got %0d want 0", n_iss); end
    checks++; if (extra_ack !== 0) begin errors++; $display("FAIL wr8_extra_ack got %0d want 0", extra_ack); end
`ifdef MP64_EXTMEM_PHY_STATS_EN
    checks++; if (stat_wr_beats !== 32'd8) begin errors++; $display("FAIL wr8_stat got %0d want 8", stat_wr_beats); end
`else
    checks++; if (stat_wr_beats !== 32'd0) begin errors++; $display("FAIL wr8_stat got %0d want 0", stat_wr_beats); end
`endif
  endtask

  task automatic test_wrap();
    logic [9:0] a;
    for (int i = 0; i < 8; i++) begin
      a = 10'h3FF + 10'(i);
      preload(a, 64'hC0DE000000000000 + 64'(i));
    end
    run_burst(32'h0000_1FF8, 1'b0, 4'd8, 8, 64'h0);
    checks++; if (timed_out) begin errors++; $display("FAIL wrap_timeout got %0d acks want 8", n_ack); end
    for (int i = 0; i < 8; i++) begin
      a = 10'h3FF + 10'(i);
      checks++; if (iss_addr[i] !== a)
        begin errors++; $display("FAIL wrap_addr[%0d] got %h want %h", i, iss_addr[i], a); end
      checks++; if (ack_data[i] !== 64'hC0DE000000000000 + 64'(i))
        begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", i, ack_data[i], 64'hC0DE000000000000 + 64'(i)); end
      checks++; if (ack_cyc[i] !== 4 * (i + 1))
        begin errors++; $display("FAIL wrap_ack_cyc[%0d] got %0d want %0d", i, ack_cyc[i], 4 * (i + 1)); end
    end
    checks++; if (we_low !== 0 || oe_on_read !== 0)
      begin errors++; $display("FAIL wrap_read_drive got we_low=%0d oe=%0d want 0/0", we_low, oe_on_read); end
  endtask

  task automatic test_len_edges();
    pulse_reset();
    run_burst(32'h0000_0040, 1'b0, 4'd0, 1, 64'h0);
    checks++; if (timed_out || n_ack !== 1) begin errors++; $display("FAIL len0_acks got %0d want 1", n_ack); end
    checks++; if (extra_ack !== 0 || n_iss !== 1)
      begin errors++; $display("FAIL len0_extra got acks+%0d issues %0d want +0 1", extra_ack, n_iss); end
    run_burst(32'h0000_0200, 1'b0, 4'd12, 8, 64'h0);
    checks++; if (timed_out || n_ack !== 8) begin errors++; $display("FAIL len12_acks got %0d want 8", n_ack); end
    checks++; if (extra_ack !== 0 || n_iss !== 8)
      begin errors++; $display("FAIL len12_extra got acks+%0d issues %0d want +0 8", extra_ack, n_iss); end
    checks++; if (ce_after !== 0) begin errors++; $display("FAIL len12_idle got ce_low=%0d want 0", ce_after); end
`ifdef MP64_EXTMEM_PHY_STATS_EN
    checks++; if (stat_rd_beats !== 32'd9) begin errors++; $display("FAIL len_stat got %0d want 9", stat_rd_beats); end
`else
    checks++; if (stat_rd_beats !== 32'd0) begin errors++; $display("FAIL len_stat got %0d want 0", stat_rd_beats); end
`endif
  endtask

  task automatic test_reset_mid_burst();
    int n, cyc;
    @(negedge clk);
    phy_addr = 32'h0; phy_wen = 1'b0; phy_burst_len = 4'd8; phy_req = 1'b1;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (phy_ack) n++;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL midrst_pre_acks got %0d want 3", n); end
    rst_n = 1'b0; phy_req = 1'b0;
    #1;
    checks++; if (phy_ack !== 1'b0 || sram_ce_n !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0)
      begin errors++; $display("FAIL midrst_ctrl got ack=%0b ce_n=%0b we_n=%0b oe=%0b want 0110",
                               phy_ack, sram_ce_n, sram_we_n, sram_dq_oe); end
    checks++; if (phy_rdata !== 64'h0 || sram_addr !== 10'h0)
      begin errors++; $display("FAIL midrst_data got rdata=%h addr=%h want 0/0", phy_rdata, sram_addr); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (phy_ack) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL midrst_post_acks got %0d want 0", n); end
    run_burst(32'h8000_0100, 1'b0, 4'd1, 1, 64'h0);
    checks++; if (timed_out || ack_cyc[0] !== 4)
      begin errors++; $display("FAIL midrst_rd_latency got %0d want 4", ack_cyc[0]); end
    checks++; if (ack_data[0] !== 64'hDEADBEEF12345678)
      begin errors++; $display("FAIL midrst_rd_data got %h want deadbeef12345678", ack_data[0]); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tile_write();
    test_wrap();
    test_len_edges();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
